// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
package wb_pkg;

  // Architectural zero register; writes to it never reach the register file.
  localparam int unsigned ZR_IDX    = 31;
  localparam int unsigned REG_COUNT = 32;
  // Widest data path the buffered entry can carry; narrower N is zero-extended.
  localparam int unsigned N_MAX     = 64;

  typedef struct packed {
    logic             live;
    logic [4:0]       wa;
    logic [N_MAX-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer for long-latency results. Entries can have their
// live bit cleared by destination match, and all live/wa fields are exported
// so the owner can build a pending-register scoreboard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  clr_en_i,
  input  logic [4:0]            clr_wa_i,
  output wb_entry_t             head_o,
  output logic [DEPTH-1:0]      live_o,
  output logic [DEPTH-1:0][4:0] wa_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and live-bit maintenance. A popped slot has its live bit
  // dropped so that only occupied entries can ever contribute to the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (clr_en_i && (mem_q[i].wa == clr_wa_i)) begin
          mem_q[i].live <= 1'b0;
        end
      end
      if (pop_i) begin
        mem_q[rd_ptr_q].live <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PTR_ONE;
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Flatten per-entry tags for the scoreboard.
  always_comb begin
    live_o = '0;
    wa_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live_o[i] = mem_q[i].live;
      wa_o[i]   = mem_q[i].wa;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle results and buffered long-latency
// results onto the register file write port, and flags decode hazards on
// registers that still have a buffered write in flight.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned N     = 64,
  parameter int unsigned ZR    = ZR_IDX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   main_we,
  input  logic [4:0]             main_wa,
  input  logic [N-1:0]           main_wd,
  input  logic                   ll_valid,
  output logic                   ll_ready,
  input  logic [4:0]             ll_wa,
  input  logic [N-1:0]           ll_wd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   stall,
  output logic                   we3,
  output logic [4:0]             wa3,
  output logic [N-1:0]           wd3,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [4:0]       ZR_A     = 5'(ZR);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                  main_hit;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic [DEPTH-1:0]      ent_live;
  logic [DEPTH-1:0][4:0] ent_wa;
  logic [REG_COUNT-1:0]  pending;

  assign main_hit   = main_we && (main_wa != ZR_A);
  assign fifo_empty = (count == '0);
  assign ll_ready   = reset && (count < FULL_CNT);
  assign push       = ll_valid && ll_ready && (ll_wa != ZR_A);

  // A long-latency result racing a same-register main write is already stale.
  always_comb begin
    push_entry      = '0;
    push_entry.live = !(main_we && (main_wa == ll_wa));
    push_entry.wa   = ll_wa;
    push_entry.wd   = N_MAX'(ll_wd);
  end

  // Port selection: main path first, otherwise retire or discard the FIFO head.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    pop = 1'b0;
    if (!reset) begin
      pop = 1'b0;
    end else if (main_hit) begin
      we3 = 1'b1;
      wa3 = main_wa;
      wd3 = main_wd;
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (head.live) begin
        we3 = 1'b1;
        wa3 = head.wa;
        wd3 = head.wd[N-1:0];
      end
    end
  end

  // Scoreboard built only from registered live entries.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) begin
        pending[ent_wa[i]] = 1'b1;
      end
    end
  end

  assign stall = reset && (((rs1 != ZR_A) && pending[rs1]) ||
                           ((rs2 != ZR_A) && pending[rs2]));

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .clr_en_i     (main_hit),
    .clr_wa_i     (main_wa),
    .head_o       (head),
    .live_o       (ent_live),
    .wa_o         (ent_wa),
    .count_o      (count)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int N     = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         main_we = 1'b0;
  logic [4:0]   main_wa = '0;
  logic [N-1:0] main_wd = '0;
  logic         ll_valid = 1'b0;
  logic         ll_ready;
  logic [4:0]   ll_wa = '0;
  logic [N-1:0] ll_wd = '0;
  logic [4:0]   rs1 = '0;
  logic [4:0]   rs2 = '0;
  logic         stall;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic [2:0]   count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .N(N), .ZR(31)) dut (
    .clk      (clk),
    .reset    (reset),
    .main_we  (main_we),
    .main_wa  (main_wa),
    .main_wd  (main_wd),
    .ll_valid (ll_valid),
    .ll_ready (ll_ready),
    .ll_wa    (ll_wa),
    .ll_wd    (ll_wd),
    .rs1      (rs1),
    .rs2      (rs2),
    .stall    (stall),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .count    (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-order list of buffered results
  typedef struct {
    bit          live;
    logic [4:0]  wa;
    logic [63:0] wd;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else begin
      int sz;
      bit hit;
      bit accept;
      sz     = q.size();
      hit    = main_we && (main_wa != 5'd31);
      accept = ll_valid && (sz < DEPTH);
      if (hit) begin
        foreach (q[i]) if (q[i].wa == main_wa) q[i].live = 1'b0;
      end else if (sz > 0) begin
        void'(q.pop_front());
      end
      if (accept && (ll_wa != 5'd31)) begin
        q.push_back('{live: !(main_we && (main_wa == ll_wa)), wa: ll_wa, wd: ll_wd});
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic        e_rdy;
    logic        e_stall;
    int          e_cnt;
    bit          addr_known;
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_rdy = 1'b0; e_stall = 1'b0; e_cnt = 0;
    addr_known = 1'b1;
    if (reset) begin
      e_cnt = q.size();
      e_rdy = (q.size() < DEPTH);
      if (main_we && (main_wa != 5'd31)) begin
        e_we = 1'b1; e_wa = main_wa; e_wd = main_wd;
      end else if (q.size() > 0) begin
        if (q[0].live) begin
          e_we = 1'b1; e_wa = q[0].wa; e_wd = q[0].wd;
        end else begin
          addr_known = 1'b0;
        end
      end
      foreach (q[i]) begin
        if (q[i].live && (((rs1 != 5'd31) && (q[i].wa == rs1)) ||
                          ((rs2 != 5'd31) && (q[i].wa == rs2)))) e_stall = 1'b1;
      end
    end
    chk("m_we3", we3, e_we);
    if (addr_known) begin
      chk("m_wa3", wa3, e_wa);
      chk("m_wd3", wd3, e_wd);
    end
    chk("m_ll_ready", ll_ready, e_rdy);
    chk("m_count", count, 64'(e_cnt));
    chk("m_stall", stall, e_stall);
    chk("m_no_zr_write", (we3 && (wa3 == 5'd31)), 1'b0);
  end

  // ---------------- stimulus
  task automatic drive(input logic mwe, input logic [4:0] mwa, input logic [63:0] mwd,
                       input logic lv, input logic [4:0] lwa, input logic [63:0] lwd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    main_we = mwe; main_wa = mwa; main_wd = mwd;
    ll_valid = lv; ll_wa = lwa; ll_wd = lwd;
    rs1 = r1; rs2 = r2;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    // Reset held: outputs forced quiet even with traffic on the inputs.
    drive(1'b1, 5'd3, 64'h22, 1'b1, 5'd5, 64'hAA, 5'd0, 5'd0);
    chk("rst_we3", we3, 1'b0);
    chk("rst_ll_ready", ll_ready, 1'b0);
    chk("rst_count", count, 0);
    idle();
    reset = 1'b1;
    #1;
    chk("rel_we3", we3, 1'b0);
    chk("rel_count", count, 0);
    chk("rel_ll_ready", ll_ready, 1'b1);
    chk("rel_stall", stall, 1'b0);

    // Basic drain
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAA, 5'd0, 5'd0);
    chk("drain_empty_we3", we3, 1'b0);
    idle();
    chk("drain_we3", we3, 1'b1);
    chk("drain_wa3", wa3, 5);
    chk("drain_wd3", wd3, 64'hAA);
    chk("drain_count1", count, 1);
    idle();
    chk("drain_count0", count, 0);

    // Priority: main path wins for two cycles, buffered x7 retires third
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    drive(1'b1, 5'd3, 64'h22, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    chk("prio_wa3_a", wa3, 3);
    chk("prio_wd3_a", wd3, 64'h22);
    drive(1'b1, 5'd3, 64'h22, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    chk("prio_wa3_b", wa3, 3);
    chk("prio_count", count, 1);
    idle();
    chk("prio_late_we3", we3, 1'b1);
    chk("prio_late_wa3", wa3, 7);
    chk("prio_late_wd3", wd3, 64'h11);

    // Cancellation of a buffered entry by a younger main write
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h1, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 64'h2, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    chk("cancel_main_wd3", wd3, 64'h2);
    chk("cancel_stall_pre", stall, 1'b1);
    idle();
    chk("cancel_dead_we3", we3, 1'b0);
    chk("cancel_dead_count", count, 1);
    idle();
    chk("cancel_popped", count, 0);
    // Same-cycle collision: stored dead
    drive(1'b1, 5'd9, 64'h3, 1'b1, 5'd9, 64'h4, 5'd0, 5'd0);
    chk("coll_wd3", wd3, 64'h3);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    chk("coll_count", count, 1);
    chk("coll_we3", we3, 1'b0);
    chk("coll_stall", stall, 1'b0);
    idle();

    // Fill to full while main path holds the port
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd20, 64'h55, 1'b1, 5'(k), 64'h100 + 64'(k), 5'd0, 5'd0);
      chk("fill_count", count, 64'(k - 1));
      chk("fill_ready", ll_ready, 1'b1);
    end
    drive(1'b1, 5'd20, 64'h55, 1'b1, 5'd6, 64'h666, 5'd0, 5'd0);
    chk("full_ready", ll_ready, 1'b0);
    chk("full_count", count, 4);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk("full_drain_wa3", wa3, 64'(k));
      chk("full_drain_wd3", wd3, 64'h100 + 64'(k));
      chk("full_drain_count", count, 64'(5 - k));
    end
    idle();
    chk("full_empty", count, 0);

    // Hazards and zero register
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 64'hC, 5'd0, 5'd0);
    drive(1'b1, 5'd20, 64'h55, 1'b0, 5'd0, 64'd0, 5'd12, 5'd31);
    chk("haz_rs1", stall, 1'b1);
    drive(1'b1, 5'd20, 64'h55, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31);
    chk("haz_none", stall, 1'b0);
    drive(1'b1, 5'd20, 64'h55, 1'b0, 5'd0, 64'd0, 5'd31, 5'd12);
    chk("haz_rs2", stall, 1'b1);
    idle();
    chk("haz_drain_wa3", wa3, 12);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFF, 5'd0, 5'd0);
    chk("zr_ready", ll_ready, 1'b1);
    idle();
    chk("zr_count", count, 0);
    chk("zr_we3", we3, 1'b0);

    // Reset while three results are buffered
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd20, 64'h55, 1'b1, 5'(k), 64'h200 + 64'(k), 5'd0, 5'd0);
    end
    drive(1'b1, 5'd20, 64'h55, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    chk("mid_count_pre", count, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_count_rst", count, 0);
    chk("mid_we3_rst", we3, 1'b0);
    chk("mid_ready_rst", ll_ready, 1'b0);
    idle();
    reset = 1'b1;
    idle();
    chk("mid_after_we3", we3, 1'b0);
    chk("mid_after_count", count, 0);
    idle();
    chk("mid_after_we3_b", we3, 1'b0);

    // Mixed traffic on a small register set, checked by the model
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(0, 3) == 0), pick_reg(), {$urandom, $urandom},
            1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom},
            pick_reg(), pick_reg());
    end
    for (int c = 0; c < 6; c++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
